// File: rtl/display_value_sequencer.sv
// Display value sequencer: a small file of signed 8-bit registers, one of
// which is presented to a downstream decimal/sign display decoder.
// The shown index advances on a debounced-by-sync pushbutton press
// (manual mode) or on a periodic scroll tick (auto mode).
//
// Ports:
//   clk, rst        - single clock, synchronous active-high reset
//   wr_en/addr/data - processor write port into the register file
//   btn_next        - raw asynchronous pushbutton (active-high)
//   auto_mode       - slide switch, 1 = auto-scroll, 0 = manual
//   val             - registered copy of the selected register
//   sel_idx         - index of the register currently shown
//   new_flag        - selected register written since it was last selected
module display_value_sequencer #(
  parameter int NUM_REGS     = 8,
  parameter int SCROLL_TICKS = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [7:0]                  wr_data,
  input  logic                        btn_next,
  input  logic                        auto_mode,
  output logic [7:0]                  val,
  output logic [$clog2(NUM_REGS)-1:0] sel_idx,
  output logic                        new_flag
);

  localparam int AW = $clog2(NUM_REGS);
  localparam int CW = $clog2(SCROLL_TICKS);
  localparam logic [CW-1:0] TERM = CW'(SCROLL_TICKS - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            cnt_run, cnt_keep;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            sync1_q, sync2_q, prev_q;
  logic [1:0]      fill_q;
  logic            press, term, adv;

  logic [7:0]      regs_q [NUM_REGS];
  logic [7:0]      regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic [AW-1:0]   sel_q, sel_d;
  logic [7:0]      val_q;
  logic            new_q;

  // ---------------------------------------------------------------------------
  // Button synchronizer and rising-edge detector.
  // fill_q tracks how far the two sync flops have refilled since reset. Until
  // sync2_q holds a genuine sample, prev_q is pinned high, so a button that is
  // already held when reset releases looks like "was high" rather than a fresh
  // 0->1 edge; it must be released and pressed again to register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'b00;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= btn_next;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= fill_q[1] ? sync2_q : 1'b1;
    end
  end

  assign press = sync2_q & ~prev_q;

  // ---------------------------------------------------------------------------
  // Mode FSM: state register / next-state / outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_MANUAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_MANUAL: if (auto_mode)  state_d = ST_AUTO;
      ST_AUTO:   if (!auto_mode) state_d = ST_MANUAL;
      default:   state_d = ST_MANUAL;
    endcase
  end

  // cnt_run: the scroll counter is live this cycle.
  // cnt_keep: it stays live next cycle too; otherwise it is parked at 0, which
  // covers both holding in manual and starting from 0 on entry to auto.
  always_comb begin
    cnt_run  = 1'b0;
    cnt_keep = 1'b0;
    case (state_q)
      ST_AUTO: begin
        cnt_run  = 1'b1;
        cnt_keep = (state_d == ST_AUTO);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scroll counter and advance. A press and a terminal count landing together
  // collapse into a single advance, and either one restarts the count.
  // ---------------------------------------------------------------------------
  assign term = cnt_run && (cnt_q == TERM);
  assign adv  = press | term;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!cnt_keep || adv) begin
      cnt_d = '0;
    end
  end

  // NUM_REGS is a power of two, so the natural AW-bit wrap is the required
  // NUM_REGS-1 -> 0 wrap.
  assign sel_d = adv ? sel_q + AW'(1) : sel_q;

  // ---------------------------------------------------------------------------
  // Register file and dirty bits. The advance clear is applied after the write
  // set, so a write and an advance onto the same index leave it clean.
  // ---------------------------------------------------------------------------
  always_comb begin
    regs_d  = regs_q;
    dirty_d = dirty_q;
    if (wr_en) begin
      regs_d[wr_addr]  = wr_data;
      dirty_d[wr_addr] = 1'b1;
    end
    if (adv) begin
      dirty_d[sel_d] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      dirty_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      new_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      dirty_q <= dirty_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      // Output stage reads the current state, giving one cycle of latency
      // from any selection or register change.
      val_q   <= regs_q[sel_q];
      new_q   <= dirty_q[sel_q];
    end
  end

  assign val      = val_q;
  assign sel_idx  = sel_q;
  assign new_flag = new_q;

endmodule
